line_framer: RTL and testbench

- Upstream neighbour of the in-line reorder stage in the JPEG2000 tile path.
- Accepts a raw, unmarked sample stream and emits the same samples on the team Axis bus with sof/eol markers, using a runtime line size and line count.
- Output drives the reorder stage's s_axis directly. Optionally applies JPEG2000 DC level shift.

---
 rtl/jpeg2k_pkg.sv | 21 ++
 rtl/axis_if.sv | 15 +
 rtl/axis_reg_slice.sv | 60 ++++++
 rtl/line_framer.sv | 138 +++++++++++++
 tb/tb_line_framer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg2k_pkg.sv
// Shared types and constants for the JPEG2000 tile-path stages.
package jpeg2k_pkg;

    localparam int JpegDataWidth = 8;

    typedef logic [JpegDataWidth-1:0] Data_t;

    // Framer control state: IDLE waits for a valid config and the first sample, RUN streams a frame.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } framer_state_e;

    // DC level shift offset 2^(width-1): flipping the MSB maps unsigned samples to two's complement.
    function automatic logic [63:0] dc_shift_offset(input int width);
        return 64'd1 << (width - 1);
    endfunction

    localparam Data_t DcShiftOffset = Data_t'(dc_shift_offset(JpegDataWidth));

endpackage

// File: rtl/axis_if.sv
// Team Axis bus: data/valid/ready handshake plus sof/eol frame markers.
interface axis_if
    import jpeg2k_pkg::*;
#(
    parameter int DataWidth = JpegDataWidth
);
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 sof;
    logic                 eol;

    modport master (output data, valid, sof, eol, input ready);
    modport slave  (input data, valid, sof, eol, output ready);
endinterface

// File: rtl/axis_reg_slice.sv
// Single-stage Axis output register with sof/eol/last sideband and a
// done pulse one cycle after the last-flagged beat is taken downstream.
module axis_reg_slice
    import jpeg2k_pkg::*;
#(
    parameter int DataWidth = JpegDataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_load,
    input  logic [DataWidth-1:0] i_data,
    input  logic                 i_sof,
    input  logic                 i_eol,
    input  logic                 i_last,
    output logic                 o_free,
    output logic                 o_done,
    axis_if.master               m_axis
);

    logic                 r_valid;
    logic [DataWidth-1:0] r_data;
    logic                 r_sof;
    logic                 r_eol;
    logic                 r_last;
    logic                 r_done;

    // Register can take a new beat when empty or when its current beat leaves this cycle.
    assign o_free       = !r_valid | m_axis.ready;
    assign o_done       = r_done;
    assign m_axis.valid = r_valid;
    assign m_axis.data  = r_data;
    assign m_axis.sof   = r_sof;
    assign m_axis.eol   = r_eol;

    // Load on acceptance, drain on downstream ready, hold everything while stalled.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with <= so every register samples pre-edge values, as the hardware does.
        if (rst_i) begin
            r_valid <= 1'b0;
            // NOTE: the data path is reset too because downstream observes data=0 after reset.
            r_data  <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= r_valid & m_axis.ready & r_last;
            if (i_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
                r_sof   <= i_sof;
                r_eol   <= i_eol;
                r_last  <= i_last;
            end else if (m_axis.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_framer.sv
// Line framer: turns a raw sample stream into an Axis stream with sof/eol
// markers for a runtime line size (W) and line count (H).
// Optional build macro LINE_FRAMER_DC_SHIFT_EN applies the JPEG2000 DC level
// shift (MSB flip) to every sample; markers and timing are unaffected.
module line_framer
    import jpeg2k_pkg::*;
#(
    parameter int DataWidth   = JpegDataWidth,
    parameter int MaxLineSize = 8,
    parameter int MaxLineNum  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [$clog2(MaxLineSize+1)-1:0]  line_size_i,
    input  logic [$clog2(MaxLineNum+1)-1:0]   line_num_i,
    axis_if.slave                             s_axis,
    axis_if.master                            m_axis,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              cfg_err_o
);

    localparam int LineSizeW = $clog2(MaxLineSize + 1);
    localparam int LineNumW  = $clog2(MaxLineNum + 1);

    framer_state_e        r_state;
    framer_state_e        w_state_next;
    logic [LineSizeW-1:0] r_w;
    logic [LineSizeW-1:0] r_col;
    logic [LineSizeW-1:0] w_w;
    logic [LineNumW-1:0]  r_h;
    logic [LineNumW-1:0]  r_row;
    logic [LineNumW-1:0]  w_h;
    logic                 w_cfg_ok;
    logic                 w_free;
    logic                 w_s_ready;
    logic                 w_accept;
    logic                 w_col_last;
    logic                 w_row_last;
    logic [DataWidth-1:0] w_data;
    logic                 w_unused_markers;

    // Raw upstream carries no framing; its markers are deliberately ignored.
    assign w_unused_markers = s_axis.sof | s_axis.eol;

    // W=1 is rejected: the downstream even/odd reorder needs at least two samples per line.
    assign w_cfg_ok = (line_size_i >= LineSizeW'(2)) && (line_size_i <= LineSizeW'(MaxLineSize)) &&
                      (line_num_i  >= LineNumW'(1))  && (line_num_i  <= LineNumW'(MaxLineNum));

    // In IDLE the live inputs are the config, so the first beat is framed with the same W/H that get frozen.
    assign w_w        = (r_state == IDLE) ? line_size_i : r_w;
    assign w_h        = (r_state == IDLE) ? line_num_i  : r_h;
    assign w_col_last = (r_col == w_w - LineSizeW'(1));
    assign w_row_last = (r_row == w_h - LineNumW'(1));
    assign w_accept   = s_axis.valid & w_s_ready;
    assign s_axis.ready = w_s_ready;

`ifdef LINE_FRAMER_DC_SHIFT_EN
    localparam logic [DataWidth-1:0] DcOffset = DataWidth'(dc_shift_offset(DataWidth));
    assign w_data = s_axis.data ^ DcOffset;
`else
    assign w_data = s_axis.data;
`endif

    // Next-state and handshake decode; ready is held low while reset is asserted.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        busy_o       = 1'b0;
        cfg_err_o    = 1'b0;
        case (r_state)
            IDLE: begin
                cfg_err_o = !w_cfg_ok;
                w_s_ready = w_cfg_ok & w_free & !rst_i;
                if (s_axis.valid & w_s_ready) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy_o    = 1'b1;
                w_s_ready = w_free & !rst_i;
                if (s_axis.valid & w_s_ready & w_col_last & w_row_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Config capture in IDLE and column/row counters advancing on each accepted sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_w   <= '0;
            r_h   <= '0;
            r_col <= '0;
            r_row <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_w <= line_size_i;
                r_h <= line_num_i;
            end
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + LineNumW'(1);
                end else begin
                    r_col <= r_col + LineSizeW'(1);
                end
            end
        end
    end

    axis_reg_slice #(
        .DataWidth (DataWidth)
    ) u_out_reg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_accept),
        .i_data (w_data),
        .i_sof  ((r_col == '0) && (r_row == '0)),
        .i_eol  (w_col_last),
        .i_last (w_col_last & w_row_last),
        .o_free (w_free),
        .o_done (done_o),
        .m_axis (m_axis)
    );

endmodule

// File: tb/tb_line_framer.sv
// Scoreboard bench for line_framer: a reference framing model pushes the
// expected beat whenever an input sample is accepted; the monitor pops and
// compares on every output handshake, and also checks done_o and stall stability.
module tb_line_framer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] line_size_i;
    logic [3:0] line_num_i;
    logic       busy_o;
    logic       done_o;
    logic       cfg_err_o;

    axis_if #(.DataWidth(8)) s_if ();
    axis_if #(.DataWidth(8)) m_if ();

    line_framer #(
        .DataWidth   (8),
        .MaxLineSize (8),
        .MaxLineNum  (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .line_size_i (line_size_i),
        .line_num_i  (line_num_i),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    rand_ready = 1'b0;

    // Reference model state (owned by the monitor).
    int    mdl_col = 0;
    int    mdl_row = 0;
    int    mdl_w   = 0;
    int    mdl_h   = 0;
    bit    mdl_run = 1'b0;
    bit    exp_done = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] expect_data(input logic [7:0] d);
`ifdef LINE_FRAMER_DC_SHIFT_EN
        return d ^ 8'h80;
`else
        return d;
`endif
    endfunction

    // Monitor: sampled on the falling edge, where handshake signals are settled for the next rising edge.
    always @(negedge clk_i) begin
        beat_t e;
        check("done_o", done_o, exp_done);
        exp_done = 1'b0;
        if (rst_i) begin
            sb.delete();
            mdl_col    = 0;
            mdl_row    = 0;
            mdl_run    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_if.valid, 1'b1);
                check("stall_data", m_if.data, prev_beat.data);
                check("stall_sof", m_if.sof, prev_beat.sof);
                check("stall_eol", m_if.eol, prev_beat.eol);
            end
            prev_stall = m_if.valid && !m_if.ready;
            prev_beat  = '{data: m_if.data, sof: m_if.sof, eol: m_if.eol, last: 1'b0};

            if (m_if.valid && m_if.ready) begin
                check("sb_has_entry", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_data", m_if.data, e.data);
                    check("out_sof", m_if.sof, e.sof);
                    check("out_eol", m_if.eol, e.eol);
                    exp_done = e.last;
                end
            end

            if (s_if.valid && s_if.ready) begin
                if (!mdl_run) begin
                    mdl_w   = int'(line_size_i);
                    mdl_h   = int'(line_num_i);
                    mdl_run = 1'b1;
                end
                e.data = expect_data(s_if.data);
                e.sof  = (mdl_col == 0) && (mdl_row == 0);
                e.eol  = (mdl_col == mdl_w - 1);
                e.last = e.eol && (mdl_row == mdl_h - 1);
                sb.push_back(e);
                if (e.eol) begin
                    mdl_col = 0;
                    if (e.last) begin
                        mdl_row = 0;
                        mdl_run = 1'b0;
                    end else begin
                        mdl_row++;
                    end
                end else begin
                    mdl_col++;
                end
            end
        end
    end

    // Downstream ready: random when enabled, otherwise left as driven by the main sequence.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_ready) m_if.ready = 1'($urandom_range(0, 1));
        end
    end

    // Hard stop in case something wedges the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Present one sample (optionally after a random idle gap) and wait, bounded, for acceptance.
    task automatic send(input logic [7:0] d, input int max_gap);
        bit ok;
        int cyc;
        if (max_gap > 0) begin
            s_if.valid = 1'b0;
            tick($urandom_range(0, max_gap));
        end
        s_if.valid = 1'b1;
        s_if.data  = d;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 100) begin
            @(negedge clk_i);
            ok = s_if.ready;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check("send_accepted", ok, 1'b1);
    endtask

    task automatic wait_drain();
        int cyc;
        s_if.valid = 1'b0;
        cyc = 0;
        while ((sb.size() != 0 || m_if.valid) && cyc < 200) begin
            tick(1);
            cyc++;
        end
        check("drained", sb.size(), 0);
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, m_if.valid, 1'b0);
        check({tag, "_m_sof"}, m_if.sof, 1'b0);
        check({tag, "_m_eol"}, m_if.eol, 1'b0);
        check({tag, "_m_data"}, m_if.data, 8'h00);
        check({tag, "_s_ready"}, s_if.ready, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
    endtask

    initial begin
        rst_i       = 1'b1;
        s_if.valid  = 1'b0;
        s_if.data   = 8'h00;
        s_if.sof    = 1'b0;
        s_if.eol    = 1'b0;
        m_if.ready  = 1'b1;
        line_size_i = 4'd8;
        line_num_i  = 4'd2;
        tick(3);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick(1);
        check("idle_cfg_err", cfg_err_o, 1'b0);
        check("idle_busy", busy_o, 1'b0);
        check("idle_ready", s_if.ready, 1'b1);

        // Basic frame W=8, H=2 at full rate.
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 0);
            if (i == 0) check("busy_run", busy_o, 1'b1);
        end
        s_if.valid = 1'b0;
        check("busy_end", busy_o, 1'b0);
        wait_drain();

        // Same frame under random input gaps and random downstream back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), 3);
        wait_drain();
        rand_ready = 1'b0;
        m_if.ready = 1'b1;
        tick(1);

        // Invalid line sizes block input; a valid size resumes acceptance.
        line_size_i = 4'd1;
        s_if.valid  = 1'b1;
        s_if.data   = 8'hAA;
        tick(3);
        check("w1_cfg_err", cfg_err_o, 1'b1);
        check("w1_s_ready", s_if.ready, 1'b0);
        check("w1_m_valid", m_if.valid, 1'b0);
        line_size_i = 4'd9;
        tick(2);
        check("w9_cfg_err", cfg_err_o, 1'b1);
        check("w9_s_ready", s_if.ready, 1'b0);
        check("w9_m_valid", m_if.valid, 1'b0);
        line_size_i = 4'd4;
        #1;
        check("w4_cfg_err", cfg_err_o, 1'b0);
        check("w4_s_ready", s_if.ready, 1'b1);
        send(8'hAA, 0);
        send(8'h00, 0);
        send(8'h80, 0);
        send(8'hFF, 0);
        send(8'h7F, 0);
        send(8'h01, 0);
        send(8'hFE, 0);
        send(8'h81, 0);
        wait_drain();

        // Line size changed mid-frame is ignored until the frame ends, then takes effect.
        line_size_i = 4'd8;
        for (int i = 0; i < 16; i++) begin
            send(8'h20 + 8'(i), 0);
            if (i == 4) line_size_i = 4'd4;
        end
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 0);
        wait_drain();

        // Reset three beats into a line; the next sample starts a fresh frame with sof.
        line_size_i = 4'd8;
        send(8'h60, 0);
        send(8'h61, 0);
        send(8'h62, 0);
        s_if.valid = 1'b0;
        rst_i = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        rst_i = 1'b0;
        send(8'h55, 0);
        for (int i = 1; i < 16; i++) send(8'h70 + 8'(i), 0);
        wait_drain();

        check("sb_final", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
